sram_bridge: RTL and testbench

SRAM_BRIDGE -- requirements
Module: sram_bridge

---
 rtl/sram_bridge.sv | 139 +++++++++++++
 tb/tb_sram_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge
// Function : CPU-bus to asynchronous SRAM bridge with registered strobes.
//            Each access runs SETUP, a WAIT_CYCLES-long ACCESS and, for
//            writes, a one-cycle data HOLD before the ACK pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bridge #(
    parameter int WAIT_CYCLES = 2,
    parameter int BANK_BITS   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [15:0]             i_addr,
    input  logic [7:0]              i_dat,
    output logic [7:0]              o_dat,
    input  logic                    i_we,
    input  logic                    i_cs,
    output logic                    o_ack,
    input  logic [BANK_BITS-1:0]    i_bank,
    output logic [16+BANK_BITS-1:0] o_sram_addr,
    output logic [7:0]              o_sram_dat,
    output logic                    o_sram_dat_oe,
    input  logic [7:0]              i_sram_dat,
    output logic                    o_sram_cs_n,
    output logic                    o_sram_oe_n,
    output logic                    o_sram_we_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       we_lat;
    logic       we_eff;
    logic       access_done;
    logic       cs_n_nxt;
    logic       oe_n_nxt;
    logic       we_n_nxt;
    logic       dat_oe_nxt;
    logic       ack_nxt;

    assign access_done = (wait_cnt == 4'd0);
    // Direction of the access the strobes are being set up for; in IDLE the
    // request is latched on this same edge, so look at the live input.
    assign we_eff = (state == IDLE) ? i_we : we_lat;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_cs) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = we_lat ? HOLD : ACK;
            HOLD:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change cleanly on
    // the edge that enters each phase.
    always_comb begin
        cs_n_nxt   = 1'b1;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        dat_oe_nxt = 1'b0;
        ack_nxt    = 1'b0;
        case (state_nxt)
            SETUP: begin
                cs_n_nxt   = 1'b0;
                oe_n_nxt   = we_eff;
                dat_oe_nxt = we_eff;
            end
            ACCESS: begin
                cs_n_nxt   = 1'b0;
                oe_n_nxt   = we_eff;
                we_n_nxt   = ~we_eff;
                dat_oe_nxt = we_eff;
            end
            HOLD: begin
                cs_n_nxt   = 1'b0;
                dat_oe_nxt = 1'b1;
            end
            ACK:     ack_nxt = 1'b1;
            default: ack_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            we_lat        <= 1'b0;
            o_dat         <= 8'h00;
            o_ack         <= 1'b0;
            o_sram_addr   <= '0;
            o_sram_dat    <= 8'h00;
            o_sram_dat_oe <= 1'b0;
            o_sram_cs_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
        end else begin
            state         <= state_nxt;
            o_ack         <= ack_nxt;
            o_sram_dat_oe <= dat_oe_nxt;
            o_sram_cs_n   <= cs_n_nxt;
            o_sram_oe_n   <= oe_n_nxt;
            o_sram_we_n   <= we_n_nxt;

            if (state == IDLE && i_cs) begin
                o_sram_addr <= {i_bank, i_addr};
                o_sram_dat  <= i_dat;
                we_lat      <= i_we;
            end

            if (state == SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ACCESS && !access_done) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == ACCESS && access_done && !we_lat) begin
                o_dat <= i_sram_dat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bridge
// Function : Directed bench for sram_bridge with a timeline-based model and
//            hand-computed literal checks, including a WAIT_CYCLES=5 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

    localparam int W  = 2;
    localparam int W2 = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr = 16'h0;
    logic [7:0]  dat = 8'h0;
    logic        we = 1'b0;
    logic        cs = 1'b0;
    logic        cs2 = 1'b0;
    logic [1:0]  bank = 2'd0;
    logic [7:0]  sram_val = 8'h00;

    logic [7:0]  o_dat, o_sram_dat, sram_in;
    logic        o_ack, o_sram_dat_oe, cs_n, oe_n, we_n;
    logic [17:0] o_sram_addr;

    logic [7:0]  o_dat2, o_sram_dat2, sram_in2;
    logic        o_ack2, o_sram_dat_oe2, cs_n2, oe_n2, we_n2;
    logic [17:0] o_sram_addr2;

    int checks = 0;
    int errors = 0;

    // SRAM pads only return data while the chip is selected for a read.
    assign sram_in  = (!cs_n && !oe_n) ? sram_val : 8'h00;
    assign sram_in2 = (!cs_n2 && !oe_n2) ? 8'h77 : 8'h00;

    always #5 clk = ~clk;

    sram_bridge #(.WAIT_CYCLES(W), .BANK_BITS(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(dat), .o_dat(o_dat),
        .i_we(we), .i_cs(cs), .o_ack(o_ack), .i_bank(bank),
        .o_sram_addr(o_sram_addr), .o_sram_dat(o_sram_dat),
        .o_sram_dat_oe(o_sram_dat_oe), .i_sram_dat(sram_in),
        .o_sram_cs_n(cs_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n)
    );

    sram_bridge #(.WAIT_CYCLES(W2), .BANK_BITS(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(dat), .o_dat(o_dat2),
        .i_we(we), .i_cs(cs2), .o_ack(o_ack2), .i_bank(bank),
        .o_sram_addr(o_sram_addr2), .o_sram_dat(o_sram_dat2),
        .o_sram_dat_oe(o_sram_dat_oe2), .i_sram_dat(sram_in2),
        .o_sram_cs_n(cs_n2), .o_sram_oe_n(oe_n2), .o_sram_we_n(we_n2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model: a transaction accepted in period acc drives fixed windows of
    // strobe activity measured in periods after acc.
    initial begin : compare
        int          edge_n, acc, ackk, k;
        bit          active;
        logic        m_we;
        logic [17:0] m_addr;
        logic [7:0]  m_dat, m_odat;
        logic        e_cs_n, e_oe_n, e_we_n, e_doe, e_ack;
        edge_n = 0; acc = 0; ackk = 0; active = 0;
        m_we = 0; m_addr = '0; m_dat = 8'h00; m_odat = 8'h00;
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                active = 0; m_addr = '0; m_odat = 8'h00;
            end else begin
                if (active && !m_we && (edge_n - 1 == acc + W + 1)) m_odat = sram_val;
                if (active && (edge_n - 1 > acc + ackk)) active = 0;
                if (!active && cs) begin
                    active = 1; acc = edge_n - 1; m_we = we;
                    m_addr = {bank, addr}; m_dat = dat;
                    ackk = we ? W + 3 : W + 2;
                end
            end
            #1;
            k = edge_n - acc;
            e_cs_n = 1; e_oe_n = 1; e_we_n = 1; e_doe = 0; e_ack = 0;
            if (active && !rst) begin
                if (!m_we) begin
                    e_cs_n = !(k >= 1 && k <= W + 1);
                    e_oe_n = e_cs_n;
                    e_ack  = (k == W + 2);
                end else begin
                    e_cs_n = !(k >= 1 && k <= W + 2);
                    e_we_n = !(k >= 2 && k <= W + 1);
                    e_doe  = (k >= 1 && k <= W + 2);
                    e_ack  = (k == W + 3);
                end
            end
            chk("cmp_ack", o_ack, e_ack);
            chk("cmp_cs_n", cs_n, e_cs_n);
            chk("cmp_oe_n", oe_n, e_oe_n);
            chk("cmp_we_n", we_n, e_we_n);
            chk("cmp_dat_oe", o_sram_dat_oe, e_doe);
            chk("cmp_sram_addr", o_sram_addr, m_addr);
            chk("cmp_o_dat", o_dat, m_odat);
            if (e_doe) chk("cmp_sram_dat", o_sram_dat, m_dat);
            chk("excl_oe_datoe", !oe_n && o_sram_dat_oe, 0);
            chk("excl_oe_we", !oe_n && !we_n, 0);
            chk("excl2_oe_datoe", !oe_n2 && o_sram_dat_oe2, 0);
            chk("excl2_oe_we", !oe_n2 && !we_n2, 0);
        end
    end

    initial begin : driver
        rst = 1'b1;
        step(); step();
        chk("rst_ack", o_ack, 0);
        chk("rst_strobes", {cs_n, oe_n, we_n}, 3'b111);
        chk("rst_dat_oe", o_sram_dat_oe, 0);
        chk("rst_o_dat", o_dat, 8'h00);
        chk("rst_sram_addr", o_sram_addr, 18'h0);
        chk("rst_sram_dat", o_sram_dat, 8'h00);
        rst = 1'b0;
        step(); step();

        // Read: bank 1, address 0x1234, SRAM returns 0xA5
        step(); bank = 2'd1; addr = 16'h1234; we = 0; cs = 1; sram_val = 8'hA5;
        step(); cs = 0; addr = 16'hBEEF; bank = 2'd2;
        chk("rd_addr_c1", o_sram_addr, 18'h11234); chk("rd_oe_c1", oe_n, 0);
        step(); chk("rd_oe_c2", oe_n, 0);
        step(); chk("rd_oe_c3", oe_n, 0); chk("rd_ack_c3", o_ack, 0);
        step(); chk("rd_ack_c4", o_ack, 1); chk("rd_dat_c4", o_dat, 8'hA5); chk("rd_oe_c4", oe_n, 1);
        step(); chk("rd_ack_c5", o_ack, 0);

        // Write: address 0x00FF, data 0x3C
        step(); addr = 16'h00FF; dat = 8'h3C; we = 1; cs = 1;
        step(); cs = 0; dat = 8'h11;
        chk("wr_we_c1", we_n, 1); chk("wr_doe_c1", o_sram_dat_oe, 1); chk("wr_sdat_c1", o_sram_dat, 8'h3C);
        step(); chk("wr_we_c2", we_n, 0); chk("wr_doe_c2", o_sram_dat_oe, 1);
        step(); chk("wr_we_c3", we_n, 0);
        step(); chk("wr_we_c4", we_n, 1); chk("wr_doe_c4", o_sram_dat_oe, 1);
        chk("wr_sdat_c4", o_sram_dat, 8'h3C); chk("wr_ack_c4", o_ack, 0);
        step(); chk("wr_ack_c5", o_ack, 1); chk("wr_doe_c5", o_sram_dat_oe, 0); chk("wr_odat_c5", o_dat, 8'hA5);
        step(); chk("wr_ack_c6", o_ack, 0);

        // Back-to-back reads with i_cs held through the ack cycle
        step(); bank = 2'd0; addr = 16'h0010; we = 0; cs = 1; sram_val = 8'hC3;
        step(); step(); step();
        step(); chk("b2b_ack_c4", o_ack, 1); chk("b2b_dat_c4", o_dat, 8'hC3);
        addr = 16'h0001; sram_val = 8'h5A;
        step(); chk("b2b_ack_c5", o_ack, 0);
        step(); cs = 0; chk("b2b_addr_c6", o_sram_addr, 18'h00001);
        step(); step();
        step(); chk("b2b_ack_c9", o_ack, 1); chk("b2b_dat_c9", o_dat, 8'h5A);
        step();

        // Read with i_cs dropped mid-transaction
        step(); bank = 2'd3; addr = 16'hABCD; we = 0; cs = 1; sram_val = 8'h0F;
        step();
        step(); cs = 0;
        step(); chk("drop_ack_c3", o_ack, 0);
        step(); chk("drop_ack_c4", o_ack, 1); chk("drop_dat_c4", o_dat, 8'h0F);
        step();

        // Reset while a write is in ACCESS
        step(); bank = 2'd1; addr = 16'h4444; dat = 8'h99; we = 1; cs = 1;
        step(); cs = 0;
        step(); chk("rstw_we_c2", we_n, 0);
        rst = 1'b1;
        #1;
        chk("rstw_strobes", {cs_n, oe_n, we_n}, 3'b111);
        chk("rstw_dat_oe", o_sram_dat_oe, 0);
        chk("rstw_o_dat", o_dat, 8'h00);
        chk("rstw_ack", o_ack, 0);
        step(); step(); chk("rstw_ack_hold", o_ack, 0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); chk($sformatf("rstw_noack_%0d", c), o_ack, 0);
        end

        // Recovery read after reset
        step(); bank = 2'd0; addr = 16'h0002; we = 0; cs = 1; sram_val = 8'h3E;
        step(); cs = 0;
        step(); step();
        step(); chk("rec_ack_c4", o_ack, 1); chk("rec_dat_c4", o_dat, 8'h3E);
        step();

        // WAIT_CYCLES=5 instance
        step(); bank = 2'd2; addr = 16'h0F0F; we = 0; cs2 = 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                cs2 = 0;
                chk("w5_addr_c1", o_sram_addr2, 18'h20F0F);
            end
            chk($sformatf("w5_oe_c%0d", c), oe_n2, (c >= 1 && c <= 6) ? 0 : 1);
            chk($sformatf("w5_ack_c%0d", c), o_ack2, (c == 7) ? 1 : 0);
            if (c == 7) chk("w5_dat_c7", o_dat2, 8'h77);
        end
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
